// File: rtl/if_fetch_queue.sv
// Instruction-fetch reader: one outstanding imem request, DEPTH-entry {pc,word} queue to decode.
// Optional IFQ_PERF_CNT_EN adds a saturating decode-starved cycle counter on port stall_cnt.
module if_fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_W-1:0]        imem_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [DATA_W-1:0]        inst_data,
    output logic [ADDR_W-1:0]        inst_pc,
    output logic [$clog2(DEPTH):0]   count
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   fetch_pc, fetch_pc_next;
    logic [ADDR_W-1:0]   addr_next;
    logic                req_next;
    logic [CW-1:0]       count_next;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [ADDR_W-1:0]   pc_mem   [DEPTH];
    logic                push, pop;
    logic [CW:0]         occ_after;
    logic                room_after;

    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? data_mem[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

    assign pop  = inst_valid & inst_ready;
    assign push = imem_ack & (state == REQ) & ~redirect_valid;

    // Occupancy once this ack lands; another request needs a free slot beyond it.
    assign occ_after  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
    assign room_after = (occ_after < (CW+1)'(DEPTH));

    assign count_next = redirect_valid ? '0 : (count + CW'(push) - CW'(pop));

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = imem_addr;

        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & ~ADDR_W'(3);
        end else if (push) begin
            fetch_pc_next = fetch_pc + ADDR_W'(4);
        end

        case (state)
            IDLE: begin
                if (redirect_valid || (count < CW'(DEPTH))) state_next = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    state_next = (redirect_valid || room_after) ? REQ : IDLE;
                end else if (redirect_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase

        // A new address is launched only when a request starts fresh; otherwise it is held until ack.
        if ((state_next == REQ) && ((state != REQ) || imem_ack)) begin
            addr_next = fetch_pc_next;
        end
        req_next = (state_next != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            imem_req  <= req_next;
            imem_addr <= addr_next;
            count     <= count_next;
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + PW'(push);
                rd_ptr <= rd_ptr + PW'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

`ifdef IFQ_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!inst_valid && inst_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: sequential fetch, full queue, redirect/drain, pc wrap,
// and the stall counter when IFQ_PERF_CNT_EN is defined.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [2:0]  count;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    if_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .count          (count)
`ifdef IFQ_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int          n_chk;
    int          n_pass;
    int          wcnt;
    int          ack_lat;
    int          n_pops;
    bit          ack_on;
    bit          man_ack;
    bit          pop_chk;
    logic [31:0] exp_pc;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One cycle: check any pop happening now, drive the memory model, then advance past the edge.
    task automatic step();
        if (pop_chk && inst_valid && inst_ready && !redirect_valid) begin
            chk("pop_pc", inst_pc, exp_pc);
            chk("pop_data", inst_data, word(exp_pc));
            exp_pc += 32'd4;
            n_pops++;
        end
        if (man_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            wcnt       = 0;
        end else if (ack_on && imem_req && !imem_ack && wcnt >= ack_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = word(imem_addr);
            wcnt       = 0;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = '0;
            if (imem_req === 1'b1) wcnt++;
            else wcnt = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        ack_on         = 1'b0;
        man_ack        = 1'b0;
        pop_chk        = 1'b0;
        ack_lat        = 1;
        wcnt           = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_pops = 0; exp_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;

        // Reset state
        do_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", inst_pc, 0);

        // 1: sequential fetch with ack one cycle after each request, decode always ready
        inst_ready = 1'b1; ack_on = 1'b1; pop_chk = 1'b1; exp_pc = 32'h0; n_pops = 0;
        for (int i = 0; i < 100 && n_pops < 16; i++) step();
        chk("t1_pops", n_pops, 16);

        // 2: decode stalled -> queue fills, requests stop, one pop restarts at 0x10
        do_reset();
        ack_on = 1'b1;
        for (int i = 0; i < 40 && count != 3'd4; i++) step();
        chk("t2_count", count, 4);
        chk("t2_req_off", imem_req, 0);
        chk("t2_head_pc", inst_pc, 0);
        step(); step();
        chk("t2_req_hold", imem_req, 0);
        pop_chk = 1'b1; exp_pc = 32'h0; n_pops = 0; inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("t2_one_pop", n_pops, 1);
        chk("t2_count_pop", count, 3);
        for (int i = 0; i < 5 && imem_req !== 1'b1; i++) step();
        chk("t2_rereq", imem_req, 1);
        chk("t2_addr", imem_addr, 32'h10);
        pop_chk = 1'b0;

        // 3: redirect to 0x103 while a request is pending, ack three cycles later
        do_reset();
        for (int i = 0; i < 5 && imem_req !== 1'b1; i++) step();
        chk("t3_req", imem_req, 1);
        chk("t3_addr0", imem_addr, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step();
        redirect_valid = 1'b0;
        chk("t3_drain_req", imem_req, 1);
        chk("t3_drain_addr", imem_addr, 0);
        step(); step();
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        chk("t3_new_addr", imem_addr, 32'h100);
        chk("t3_new_req", imem_req, 1);
        chk("t3_count", count, 0);
        chk("t3_valid", inst_valid, 0);
        ack_on = 1'b1; inst_ready = 1'b1; pop_chk = 1'b1; exp_pc = 32'h100; n_pops = 0;
        for (int i = 0; i < 30 && n_pops < 2; i++) step();
        chk("t3_pops", n_pops, 2);

        // 4: redirect in the same cycle as ack and pop with two entries queued
        do_reset();
        ack_on = 1'b1;
        for (int i = 0; i < 30 && count != 3'd2; i++) step();
        chk("t4_count2", count, 2);
        chk("t4_req", imem_req, 1);
        chk("t4_addr8", imem_addr, 32'h8);
        ack_on = 1'b0; man_ack = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        man_ack = 1'b0; redirect_valid = 1'b0;
        chk("t4_count0", count, 0);
        chk("t4_valid", inst_valid, 0);
        chk("t4_req2", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h200);
        ack_on = 1'b1; pop_chk = 1'b1; exp_pc = 32'h200; n_pops = 0;
        for (int i = 0; i < 30 && n_pops < 2; i++) step();
        chk("t4_pops", n_pops, 2);

        // 5: fetch address wraps from 0xFFFFFFFC to 0x0
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("t5_req", imem_req, 1);
        chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
        ack_on = 1'b1; inst_ready = 1'b1; pop_chk = 1'b1; exp_pc = 32'hFFFF_FFFC; n_pops = 0;
        for (int i = 0; i < 30 && n_pops < 3; i++) step();
        chk("t5_pops", n_pops, 3);

`ifdef IFQ_PERF_CNT_EN
        // 6: decode-starved cycle counter
        do_reset();
        chk("t6_rst", stall_cnt, 0);
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("t6_five", stall_cnt, 5);
        do_reset();
        chk("t6_rst2", stall_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (checks so far %0d)", n_chk);
        $fatal(1);
    end

endmodule
